drc_update_ctrl: RTL and testbench
==================================

Name: drc_update_ctrl

Overview:
Stage directly downstream of the tag comparator. It consumes the per-request verdict (hit/hit_way/we/ecc) and the delayed tag/index/data/syndrome/err, and issues the single registered write command to the tag and data arrays. It maintains a per-set tree-PLRU, allocates a victim on host-write miss, scrubs corrected ECC data back into the hit way, and runs a full-array invalidate sweep on request.

Parameters:
N_WAY, 4, ways per set; fixed 4 for tree-PLRU, enforced by elaboration assertion
TAG_SIZE, 20, tag width without valid bit
IDX_SIZE, 4, index width; 2**IDX_SIZE sets
WAY_WIDTH, 2, log2(N_WAY)

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
tag_i  in  TAG_SIZE  delayed tag from comparator
index_i  in  IDX_SIZE  delayed index
data_i  in  272  delayed host/ECC-corrected data
syndrome_i  in  32  delayed syndrome, passed to scrub log only
err_i  in  8  delayed per-lane ECC error flags
hit_i  in  1  comparator hit
hit_way_i  in  WAY_WIDTH  hit way
we_i  in  1  host write request valid this cycle
ecc_i  in  1  ECC scrub request valid this cycle
rd_i  in  1  host read request valid this cycle
flush_i  in  1  pulse: invalidate entire array
busy_o  out  1  upstream must hold new requests
wr_en_o  out  1  array write strobe
wr_way_o  out  WAY_WIDTH  way written
wr_index_o  out  IDX_SIZE  set written
wr_tag_o  out  TAG_SIZE+1  {valid,tag} written to tag RAM
wr_data_o  out  272  data written to data RAM
wr_data_en_o  out  1  data RAM write enable (0 during flush)
miss_o  out  1  one-cycle pulse on host read miss
scrub_cnt_o  out  16  saturating count of scrub writebacks
last_syndrome_o  out  32  syndrome of most recent scrub

Behaviour:
- Reset: all outputs 0; PLRU bits all 0; state IDLE; counters 0.
- All outputs registered; one-cycle latency from request inputs to wr_*/miss_o.
- Priority per cycle: we_i > ecc_i > rd_i; at most one acted on. Lower-priority inputs ignored that cycle.
- Host write hit: write {1,tag_i}, data_i to hit_way_i; PLRU touch hit_way_i.
- Host write miss: victim = PLRU victim of index_i; write {1,tag_i}, data_i to victim; PLRU touch victim.
- Host read hit: no write; PLRU touch. Read miss: miss_o=1 for one cycle, no allocate, PLRU unchanged.
- ECC: if hit_i and |err_i: write data_i to hit_way_i with tag {1,tag_i}; scrub_cnt_o += 1, saturating at 16'hFFFF; last_syndrome_o <= syndrome_i; PLRU unchanged. Otherwise no action.
- PLRU (per set, 3 bits b0 root, b1 ways0/1, b2 ways2/3): touch way w sets b0=~w[1], and b1=~w[0] if w[1]=0 else b2=~w[0]. Victim: b0=0 -> ways0/1 via b1, else ways2/3 via b2.
- Same-index back-to-back ops: PLRU read uses post-update state (internal bypass of previous cycle's update).
- FSM IDLE/FLUSH/DONE:
  - IDLE + flush_i -> FLUSH, counter=0, busy_o=1.
  - FLUSH: each cycle write wr_tag_o=0 to {counter set, way}, wr_data_en_o=0; iterate ways 0..N_WAY-1 then next set; PLRU of set cleared. After set 2**IDX_SIZE-1, way N_WAY-1 -> DONE.
  - DONE: busy_o drops, -> IDLE. Flush takes N_WAY*2**IDX_SIZE+1 cycles.
- Requests arriving while busy_o=1 are a protocol violation; assertion fires, request dropped. flush_i while in FLUSH ignored.
- flush_i together with a request in IDLE: the request completes this cycle; flush starts next cycle.
- Async reset mid-flush: immediate return to IDLE; array content undefined to the block.

Optional Feature:
DRC_UPD_STATS_EN: adds outputs hit_cnt_o and miss_cnt_o (32-bit, wrapping), counting host read+write hits and misses; cleared by rst and on flush entry. Without it, the ports and logic are absent.

Decomposition:
- drc_pkg: req_op_e enum (OP_NONE/OP_WR/OP_ECC/OP_RD), upd_state_e enum (IDLE/FLUSH/DONE), plru_t typedef (logic[2:0]), DATA_W=272 constant, SCRUB_CNT_W=16.
- Sub-module drc_plru: PLRU storage array plus touch/victim logic with same-index bypass.

Test Plan:
- Reset then write miss to index 3, tag 0x12345, all PLRU 0 -> next cycle wr_en_o=1, way 0, wr_tag_o={1,0x12345}; next write miss to index 3 -> way 2.
- Write miss to index 5 four times, ways 0,2,1,3, then hit touch way 0, then miss -> victim way 2.
- Read miss index 1 -> miss_o pulses once, wr_en_o=0; read hit way 3 -> no write, next victim for index 1 is way 0.
- ECC hit way 1, err_i=8'h04, syndrome 0xDEAD0001 -> scrub write to way 1, scrub_cnt_o=1, last_syndrome_o=0xDEAD0001; err_i=0 -> no write.
- flush_i with IDX_SIZE=4 -> busy_o high 64 cycles, 64 writes with wr_tag_o=0, wr_data_en_o=0, then IDLE; rst asserted mid-flush -> busy_o=0 immediately.
- we_i and ecc_i same cycle -> only host write issued; scrub_cnt_o unchanged.

Source files
------------

// File: rtl/drc_pkg.sv
// Shared types, widths and tree-PLRU helpers for the tag/data array update stage.
package drc_pkg;

    localparam int unsigned DATA_W      = 272;
    localparam int unsigned SCRUB_CNT_W = 16;
    localparam int unsigned SYND_W      = 32;
    localparam int unsigned ERR_W       = 8;
    localparam int unsigned STAT_W      = 32;

    typedef enum logic [1:0] {
        OP_NONE,
        OP_WR,
        OP_ECC,
        OP_RD
    } req_op_e;

    typedef enum logic [1:0] {
        IDLE,
        FLUSH,
        DONE
    } upd_state_e;

    // bit 0 root, bit 1 selects within ways 0/1, bit 2 within ways 2/3
    typedef logic [2:0] plru_t;

    // Point every node on the path away from the touched way
    function automatic plru_t plru_touch(plru_t p, logic [1:0] w);
        plru_t r;
        r    = p;
        r[0] = ~w[1];
        if (!w[1]) begin
            r[1] = ~w[0];
        end else begin
            r[2] = ~w[0];
        end
        return r;
    endfunction

    function automatic logic [1:0] plru_victim(plru_t p);
        return p[0] ? {1'b1, p[2]} : {1'b0, p[1]};
    endfunction

endpackage

// File: rtl/drc_plru.sv
// Per-set tree-PLRU storage. Updates land one cycle late, so reads bypass the
// pending update to always see post-update state for back-to-back same-set ops.
module drc_plru
    import drc_pkg::*;
#(
    parameter int unsigned IDX_SIZE = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [IDX_SIZE-1:0] idx,
    input  logic                touch_en,
    input  logic [1:0]          touch_way,
    input  logic                clear_en,
    output logic [1:0]          victim_c
);

    localparam int unsigned SETS = 2 ** IDX_SIZE;

    plru_t               mem_q [SETS];
    logic                pend_vld_q;
    logic [IDX_SIZE-1:0] pend_idx_q;
    plru_t               pend_bits_q;
    plru_t               cur_c;
    plru_t               new_c;

    always_comb begin
        cur_c    = mem_q[idx];
        if (pend_vld_q && (pend_idx_q == idx)) begin
            cur_c = pend_bits_q;
        end
        new_c    = clear_en ? plru_t'(0) : plru_touch(cur_c, touch_way);
        victim_c = plru_victim(cur_c);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SETS; i++) begin
                mem_q[i] <= '0;
            end
            pend_vld_q  <= 1'b0;
            pend_idx_q  <= '0;
            pend_bits_q <= '0;
        end else begin
            if (pend_vld_q) begin
                mem_q[pend_idx_q] <= pend_bits_q;
            end
            pend_vld_q <= touch_en || clear_en;
            if (touch_en || clear_en) begin
                pend_idx_q  <= idx;
                pend_bits_q <= new_c;
            end
        end
    end

endmodule

// File: rtl/drc_update_ctrl.sv
// Array write-command stage: host write/allocate, ECC scrub writeback, read-miss
// pulse, and full-array invalidate sweep. Optional hit/miss stats: DRC_UPD_STATS_EN.
module drc_update_ctrl
    import drc_pkg::*;
#(
    parameter int unsigned N_WAY     = 4,
    parameter int unsigned TAG_SIZE  = 20,
    parameter int unsigned IDX_SIZE  = 4,
    parameter int unsigned WAY_WIDTH = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [TAG_SIZE-1:0]    tag_i,
    input  logic [IDX_SIZE-1:0]    index_i,
    input  logic [DATA_W-1:0]      data_i,
    input  logic [SYND_W-1:0]      syndrome_i,
    input  logic [ERR_W-1:0]       err_i,
    input  logic                   hit_i,
    input  logic [WAY_WIDTH-1:0]   hit_way_i,
    input  logic                   we_i,
    input  logic                   ecc_i,
    input  logic                   rd_i,
    input  logic                   flush_i,
    output logic                   busy_o,
    output logic                   wr_en_o,
    output logic [WAY_WIDTH-1:0]   wr_way_o,
    output logic [IDX_SIZE-1:0]    wr_index_o,
    output logic [TAG_SIZE:0]      wr_tag_o,
    output logic [DATA_W-1:0]      wr_data_o,
    output logic                   wr_data_en_o,
    output logic                   miss_o,
    output logic [SCRUB_CNT_W-1:0] scrub_cnt_o,
    output logic [SYND_W-1:0]      last_syndrome_o
`ifdef DRC_UPD_STATS_EN
    ,
    output logic [STAT_W-1:0]      hit_cnt_o,
    output logic [STAT_W-1:0]      miss_cnt_o
`endif
);

    localparam int unsigned FLUSH_W = IDX_SIZE + WAY_WIDTH;
    localparam logic [FLUSH_W-1:0] FLUSH_LAST = '1;

    if (N_WAY != 4 || WAY_WIDTH != 2) begin : g_bad_cfg
        $error("drc_update_ctrl: tree-PLRU supports only N_WAY=4, WAY_WIDTH=2");
    end

    upd_state_e             state_q, state_nxt;
    logic [FLUSH_W-1:0]     flush_cnt_q, flush_cnt_nxt;
    req_op_e                op_c;

    logic                   busy_nxt, wr_en_nxt, wr_data_en_nxt, miss_nxt;
    logic [WAY_WIDTH-1:0]   wr_way_nxt;
    logic [IDX_SIZE-1:0]    wr_index_nxt;
    logic [TAG_SIZE:0]      wr_tag_nxt;
    logic [DATA_W-1:0]      wr_data_nxt;
    logic [SCRUB_CNT_W-1:0] scrub_cnt_nxt;
    logic [SYND_W-1:0]      last_syndrome_nxt;

    logic [IDX_SIZE-1:0]    plru_idx_c;
    logic                   plru_touch_c, plru_clear_c;
    logic [1:0]             plru_way_c, victim_c;

    drc_plru #(.IDX_SIZE(IDX_SIZE)) u_plru (
        .clk       (clk),
        .rst       (rst),
        .idx       (plru_idx_c),
        .touch_en  (plru_touch_c),
        .touch_way (plru_way_c),
        .clear_en  (plru_clear_c),
        .victim_c  (victim_c)
    );

    // Request arbitration, command build and flush sequencing
    always_comb begin
        state_nxt         = state_q;
        flush_cnt_nxt     = flush_cnt_q;
        op_c              = OP_NONE;
        busy_nxt          = 1'b0;
        wr_en_nxt         = 1'b0;
        wr_way_nxt        = '0;
        wr_index_nxt      = '0;
        wr_tag_nxt        = '0;
        wr_data_nxt       = '0;
        wr_data_en_nxt    = 1'b0;
        miss_nxt          = 1'b0;
        scrub_cnt_nxt     = scrub_cnt_o;
        last_syndrome_nxt = last_syndrome_o;
        plru_idx_c        = index_i;
        plru_touch_c      = 1'b0;
        plru_clear_c      = 1'b0;
        plru_way_c        = 2'(hit_way_i);

        if (state_q != FLUSH) begin
            if (we_i) begin
                op_c = OP_WR;
            end else if (ecc_i) begin
                op_c = OP_ECC;
            end else if (rd_i) begin
                op_c = OP_RD;
            end
        end

        case (op_c)
            OP_WR: begin
                plru_way_c     = hit_i ? 2'(hit_way_i) : victim_c;
                plru_touch_c   = 1'b1;
                wr_en_nxt      = 1'b1;
                wr_way_nxt     = WAY_WIDTH'(plru_way_c);
                wr_index_nxt   = index_i;
                wr_tag_nxt     = {1'b1, tag_i};
                wr_data_nxt    = data_i;
                wr_data_en_nxt = 1'b1;
            end
            OP_ECC: begin
                if (hit_i && (|err_i)) begin
                    wr_en_nxt         = 1'b1;
                    wr_way_nxt        = hit_way_i;
                    wr_index_nxt      = index_i;
                    wr_tag_nxt        = {1'b1, tag_i};
                    wr_data_nxt       = data_i;
                    wr_data_en_nxt    = 1'b1;
                    last_syndrome_nxt = syndrome_i;
                    if (scrub_cnt_o != '1) begin
                        scrub_cnt_nxt = scrub_cnt_o + SCRUB_CNT_W'(1);
                    end
                end
            end
            OP_RD: begin
                plru_touch_c = hit_i;
                miss_nxt     = !hit_i;
            end
            default: ;
        endcase

        case (state_q)
            IDLE, DONE: begin
                state_nxt = IDLE;
                if (flush_i) begin
                    state_nxt     = FLUSH;
                    flush_cnt_nxt = '0;
                    busy_nxt      = 1'b1;
                end
            end
            FLUSH: begin
                // Invalidate one {set, way} per cycle, ways fastest
                wr_en_nxt      = 1'b1;
                wr_way_nxt     = flush_cnt_q[WAY_WIDTH-1:0];
                wr_index_nxt   = flush_cnt_q[FLUSH_W-1:WAY_WIDTH];
                plru_idx_c     = flush_cnt_q[FLUSH_W-1:WAY_WIDTH];
                plru_clear_c   = 1'b1;
                flush_cnt_nxt  = flush_cnt_q + FLUSH_W'(1);
                busy_nxt       = (flush_cnt_q != FLUSH_LAST);
                if (flush_cnt_q == FLUSH_LAST) begin
                    state_nxt = DONE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= IDLE;
            flush_cnt_q     <= '0;
            busy_o          <= 1'b0;
            wr_en_o         <= 1'b0;
            wr_way_o        <= '0;
            wr_index_o      <= '0;
            wr_tag_o        <= '0;
            wr_data_o       <= '0;
            wr_data_en_o    <= 1'b0;
            miss_o          <= 1'b0;
            scrub_cnt_o     <= '0;
            last_syndrome_o <= '0;
        end else begin
            state_q         <= state_nxt;
            flush_cnt_q     <= flush_cnt_nxt;
            busy_o          <= busy_nxt;
            wr_en_o         <= wr_en_nxt;
            wr_way_o        <= wr_way_nxt;
            wr_index_o      <= wr_index_nxt;
            wr_tag_o        <= wr_tag_nxt;
            wr_data_o       <= wr_data_nxt;
            wr_data_en_o    <= wr_data_en_nxt;
            miss_o          <= miss_nxt;
            scrub_cnt_o     <= scrub_cnt_nxt;
            last_syndrome_o <= last_syndrome_nxt;
        end
    end

`ifdef DRC_UPD_STATS_EN
    logic host_hit_c, host_miss_c, flush_start_c;

    always_comb begin
        host_hit_c    = ((op_c == OP_WR) || (op_c == OP_RD)) && hit_i;
        host_miss_c   = ((op_c == OP_WR) || (op_c == OP_RD)) && !hit_i;
        flush_start_c = (state_q != FLUSH) && flush_i;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_cnt_o  <= '0;
            miss_cnt_o <= '0;
        end else if (flush_start_c) begin
            hit_cnt_o  <= '0;
            miss_cnt_o <= '0;
        end else begin
            if (host_hit_c) begin
                hit_cnt_o <= hit_cnt_o + STAT_W'(1);
            end
            if (host_miss_c) begin
                miss_cnt_o <= miss_cnt_o + STAT_W'(1);
            end
        end
    end
`endif

    // Upstream must not present requests while the sweep owns the arrays
    a_no_req_when_busy: assert property (@(posedge clk) disable iff (rst)
        busy_o |-> !(we_i || ecc_i || rd_i))
        else $error("drc_update_ctrl: request while busy_o, dropped");

endmodule

// File: tb/tb_drc_update_ctrl.sv
// Scoreboard bench for drc_update_ctrl: expected write commands are queued at
// drive time from a reference PLRU/scrub model and popped one cycle later.
module tb_drc_update_ctrl;

    logic         clk, rst;
    logic [19:0]  tag_i;
    logic [3:0]   index_i;
    logic [271:0] data_i;
    logic [31:0]  syndrome_i;
    logic [7:0]   err_i;
    logic         hit_i, we_i, ecc_i, rd_i, flush_i;
    logic [1:0]   hit_way_i;
    logic         busy_o, wr_en_o, wr_data_en_o, miss_o;
    logic [1:0]   wr_way_o;
    logic [3:0]   wr_index_o;
    logic [20:0]  wr_tag_o;
    logic [271:0] wr_data_o;
    logic [15:0]  scrub_cnt_o;
    logic [31:0]  last_syndrome_o;
`ifdef DRC_UPD_STATS_EN
    logic [31:0]  hit_cnt_o, miss_cnt_o;
`endif

    drc_update_ctrl dut (
        .clk             (clk),
        .rst             (rst),
        .tag_i           (tag_i),
        .index_i         (index_i),
        .data_i          (data_i),
        .syndrome_i      (syndrome_i),
        .err_i           (err_i),
        .hit_i           (hit_i),
        .hit_way_i       (hit_way_i),
        .we_i            (we_i),
        .ecc_i           (ecc_i),
        .rd_i            (rd_i),
        .flush_i         (flush_i),
        .busy_o          (busy_o),
        .wr_en_o         (wr_en_o),
        .wr_way_o        (wr_way_o),
        .wr_index_o      (wr_index_o),
        .wr_tag_o        (wr_tag_o),
        .wr_data_o       (wr_data_o),
        .wr_data_en_o    (wr_data_en_o),
        .miss_o          (miss_o),
        .scrub_cnt_o     (scrub_cnt_o),
        .last_syndrome_o (last_syndrome_o)
`ifdef DRC_UPD_STATS_EN
        ,
        .hit_cnt_o       (hit_cnt_o),
        .miss_cnt_o      (miss_cnt_o)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic         wr_en;
        logic [1:0]   way;
        logic [3:0]   idx;
        logic [20:0]  tag;
        logic         data_en;
        logic         miss;
        logic [271:0] data;
    } obs_t;

    obs_t        sb[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [2:0]  plru_m [16];
    logic [15:0] scrub_m;
    logic [31:0] syn_m;

    // Reference tree-PLRU, written as explicit per-way tables
    function automatic logic [1:0] m_victim(input logic [2:0] b);
        if (!b[0]) return b[1] ? 2'd1 : 2'd0;
        else       return b[2] ? 2'd3 : 2'd2;
    endfunction

    function automatic logic [2:0] m_touch(input logic [2:0] b, input logic [1:0] w);
        case (w)
            2'd0:    return {b[2], 1'b1, 1'b1};
            2'd1:    return {b[2], 1'b0, 1'b1};
            2'd2:    return {1'b1, b[1], 1'b0};
            default: return {1'b0, b[1], 1'b0};
        endcase
    endfunction

    function automatic obs_t sample();
        obs_t o;
        o.wr_en   = wr_en_o;
        o.way     = wr_way_o;
        o.idx     = wr_index_o;
        o.tag     = wr_tag_o;
        o.data_en = wr_data_en_o;
        o.miss    = miss_o;
        o.data    = wr_data_o;
        return o;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) plru_m[i] = 3'b000;
        scrub_m = 16'h0;
        syn_m   = 32'h0;
    endtask

    // Drive one request cycle, queue the expected command, advance past the edge
    task automatic drive(input logic we, input logic ecc, input logic rd, input logic fl,
                         input logic hit, input logic [1:0] hw, input logic [3:0] idx,
                         input logic [19:0] tag, input logic [271:0] d,
                         input logic [7:0] err, input logic [31:0] syn);
        obs_t e;
        logic [1:0] w;
        we_i = we; ecc_i = ecc; rd_i = rd; flush_i = fl; hit_i = hit; hit_way_i = hw;
        index_i = idx; tag_i = tag; data_i = d; err_i = err; syndrome_i = syn;
        e = '0;
        if (we) begin
            w = hit ? hw : m_victim(plru_m[idx]);
            e.wr_en = 1'b1; e.way = w; e.idx = idx; e.tag = {1'b1, tag};
            e.data_en = 1'b1; e.data = d;
            plru_m[idx] = m_touch(plru_m[idx], w);
        end else if (ecc) begin
            if (hit && (err != 8'h00)) begin
                e.wr_en = 1'b1; e.way = hw; e.idx = idx; e.tag = {1'b1, tag};
                e.data_en = 1'b1; e.data = d;
                if (scrub_m != 16'hFFFF) scrub_m = scrub_m + 16'h1;
                syn_m = syn;
            end
        end else if (rd) begin
            if (hit) plru_m[idx] = m_touch(plru_m[idx], hw);
            else     e.miss = 1'b1;
        end
        sb.push_back(e);
        @(posedge clk);
        #1;
        we_i = 1'b0; ecc_i = 1'b0; rd_i = 1'b0; flush_i = 1'b0;
        hit_i = 1'b0; err_i = 8'h00;
    endtask

    function automatic logic [271:0] pat(input logic [31:0] seed);
        logic [271:0] d;
        d = '0;
        for (int k = 0; k < 9; k++) d = {d[239:0], seed ^ (32'h9E3779B9 * 32'(k + 1))};
        return d;
    endfunction

    task automatic test_reset();
        obs_t got;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        got = sample();
        n_tests++;
        if (got !== obs_t'(0)) begin
            n_fail++;
            $display("FAIL reset_cmd: got %h required 0", got);
        end
        n_tests++;
        if ({busy_o, scrub_cnt_o, last_syndrome_o} !== 49'h0) begin
            n_fail++;
            $display("FAIL reset_status: busy %b scrub %h syn %h required all 0",
                     busy_o, scrub_cnt_o, last_syndrome_o);
        end
        @(negedge clk) rst = 1'b0;
        @(posedge clk);
        #1;
        model_reset();
    endtask

    task automatic test_write_miss();
        logic [19:0] tags [2] = '{20'h12345, 20'h0ABCD};
        logic [1:0]  ways [2] = '{2'd0, 2'd2};
        obs_t e, got;
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 4'd3, tags[i], pat(32'(i)), 8'h00, 32'h0);
            e = sb.pop_front(); got = sample();
            n_tests++;
            if (got !== e || got.way !== ways[i]) begin
                n_fail++;
                $display("FAIL write_miss[%0d]: got %h required %h (way %0d)", i, got, e, ways[i]);
            end
        end
    endtask

    task automatic test_plru_seq();
        logic       hits [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        logic [1:0] ways [6] = '{2'd0, 2'd2, 2'd1, 2'd3, 2'd0, 2'd2};
        obs_t e, got;
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 1'b0, 1'b0, 1'b0, hits[i], 2'd0, 4'd5, 20'(32'h500 + i),
                  pat(32'(i + 16)), 8'h00, 32'h0);
            e = sb.pop_front(); got = sample();
            n_tests++;
            if (got !== e || got.way !== ways[i]) begin
                n_fail++;
                $display("FAIL plru_seq[%0d]: got %h required %h (way %0d)", i, got, e, ways[i]);
            end
        end
    endtask

    task automatic test_read();
        logic       rds  [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        logic       wes  [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        logic       hits [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        logic       miss [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
        logic       wen  [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        obs_t e, got;
        for (int i = 0; i < 4; i++) begin
            drive(wes[i], 1'b0, rds[i], 1'b0, hits[i], 2'd3, 4'd1, 20'h00111,
                  pat(32'h77), 8'h00, 32'h0);
            e = sb.pop_front(); got = sample();
            n_tests++;
            if (got !== e || got.miss !== miss[i] || got.wr_en !== wen[i] ||
                (wen[i] && got.way !== 2'd0)) begin
                n_fail++;
                $display("FAIL read[%0d]: got %h required %h", i, got, e);
            end
        end
    endtask

    task automatic test_ecc();
        logic       hits [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
        logic [7:0] errs [4] = '{8'h04, 8'h00, 8'h10, 8'h00};
        logic       wes  [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        obs_t e, got;
        for (int i = 0; i < 4; i++) begin
            drive(wes[i], !wes[i], 1'b0, 1'b0, hits[i], 2'd1, 4'd2, 20'h2EC0,
                  pat(32'(i + 40)), errs[i], 32'hDEAD0001 + 32'(i));
            e = sb.pop_front(); got = sample();
            n_tests++;
            if (got !== e || (i == 0 && got.way !== 2'd1) || (i == 1 && got.wr_en !== 1'b0) ||
                (i == 3 && got.way !== 2'd0)) begin
                n_fail++;
                $display("FAIL ecc[%0d]: got %h required %h", i, got, e);
            end
            n_tests++;
            if (scrub_cnt_o !== 16'd1 || last_syndrome_o !== 32'hDEAD0001) begin
                n_fail++;
                $display("FAIL ecc_log[%0d]: scrub %0d syn %h required 1 DEAD0001",
                         i, scrub_cnt_o, last_syndrome_o);
            end
        end
    endtask

    task automatic test_priority();
        logic wes  [2] = '{1'b1, 1'b0};
        logic rds  [2] = '{1'b1, 1'b1};
        obs_t e, got;
        for (int i = 0; i < 2; i++) begin
            drive(wes[i], 1'b1, rds[i], 1'b0, 1'b1, 2'd1, 4'd6, 20'h00606,
                  pat(32'(i + 60)), 8'hFF, 32'hCAFE0000 + 32'(i));
            e = sb.pop_front(); got = sample();
            n_tests++;
            if (got !== e || scrub_cnt_o !== scrub_m || scrub_cnt_o !== 16'(i + 1) ||
                last_syndrome_o !== syn_m) begin
                n_fail++;
                $display("FAIL priority[%0d]: got %h scrub %0d required %h scrub %0d",
                         i, got, scrub_cnt_o, e, i + 1);
            end
        end
    endtask

    task automatic test_back_to_back();
        obs_t e, got;
        logic [31:0]  r;
        logic [271:0] d;
        for (int i = 0; i < 48; i++) begin
            r = $urandom;
            d = '0;
            for (int k = 0; k < 9; k++) d = {d[239:0], 32'($urandom)};
            drive(r[0], r[1], r[2], 1'b0, r[3], r[5:4], 4'(4'd8 + 4'(r[7:6] & 2'(r[30]))),
                  r[27:8], d, r[28] ? 8'(r[31:29]) : 8'h00, $urandom);
            e = sb.pop_front(); got = sample();
            n_tests++;
            if (got !== e || scrub_cnt_o !== scrub_m || last_syndrome_o !== syn_m) begin
                n_fail++;
                $display("FAIL b2b[%0d]: got %h scrub %0d required %h scrub %0d",
                         i, got, scrub_cnt_o, e, scrub_m);
            end
        end
    endtask

    task automatic test_flush();
        obs_t e, got;
        int busy_cnt, wr_cnt;
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 4'd4, 20'h0F1F1, pat(32'h99), 8'h00, 32'h0);
        e = sb.pop_front(); got = sample();
        n_tests++;
        if (got !== e || busy_o !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_start: got %h busy %b required %h busy 1", got, busy_o, e);
        end
        for (int i = 0; i < 16; i++) plru_m[i] = 3'b000;
        for (int c = 0; c < 64; c++) begin
            e = '0; e.wr_en = 1'b1; e.way = 2'(c % 4); e.idx = 4'(c / 4);
            sb.push_back(e);
        end
        busy_cnt = busy_o ? 1 : 0;
        wr_cnt   = 0;
        for (int t = 0; t < 100; t++) begin
            @(posedge clk);
            #1;
            if (busy_o) busy_cnt++;
            if (wr_en_o) begin
                wr_cnt++;
                got = sample();
                e = (sb.size() != 0) ? sb.pop_front() : obs_t'(0);
                n_tests++;
                if (got !== e) begin
                    n_fail++;
                    $display("FAIL flush_wr[%0d]: got %h required %h", wr_cnt - 1, got, e);
                end
            end
            if (!busy_o) break;
        end
        n_tests++;
        if (busy_cnt != 64 || wr_cnt != 64 || sb.size() != 0) begin
            n_fail++;
            $display("FAIL flush_len: busy %0d writes %0d left %0d required 64 64 0",
                     busy_cnt, wr_cnt, sb.size());
            sb.delete();
        end
        @(posedge clk);
        #1;
        n_tests++;
        if (wr_en_o !== 1'b0 || busy_o !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_done: wr_en %b busy %b required 0 0", wr_en_o, busy_o);
        end
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 4'd4, 20'h0F1F2, pat(32'h9A), 8'h00, 32'h0);
        e = sb.pop_front(); got = sample();
        n_tests++;
        if (got !== e || got.way !== 2'd0) begin
            n_fail++;
            $display("FAIL flush_plru: got %h required %h (way 0)", got, e);
        end
    endtask

    task automatic test_reset_mid_flush();
        obs_t e, got;
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 4'd0, 20'h0, '0, 8'h00, 32'h0);
        e = sb.pop_front(); got = sample();
        n_tests++;
        if (got !== e || busy_o !== 1'b1) begin
            n_fail++;
            $display("FAIL rstflush_start: got %h busy %b required %h busy 1", got, busy_o, e);
        end
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        n_tests++;
        if (busy_o !== 1'b0 || wr_en_o !== 1'b0 || scrub_cnt_o !== 16'h0) begin
            n_fail++;
            $display("FAIL rstflush_async: busy %b wr_en %b scrub %0d required 0 0 0",
                     busy_o, wr_en_o, scrub_cnt_o);
        end
        @(negedge clk) rst = 1'b0;
        @(posedge clk);
        #1;
        model_reset();
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 4'd3, 20'h12345, pat(32'(i)), 8'h00, 32'h0);
            e = sb.pop_front(); got = sample();
            n_tests++;
            if (got !== e || got.way !== 2'(i * 2)) begin
                n_fail++;
                $display("FAIL rstflush_alloc[%0d]: got %h required %h", i, got, e);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        {we_i, ecc_i, rd_i, flush_i, hit_i} = '0;
        hit_way_i = '0; index_i = '0; tag_i = '0; data_i = '0; err_i = '0; syndrome_i = '0;
        model_reset();
        test_reset();
        test_write_miss();
        test_plru_seq();
        test_read();
        test_ecc();
        test_priority();
        test_back_to_back();
        test_flush();
        test_reset_mid_flush();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time bound");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "timeout");
    end

endmodule
